ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage iterative multiply/divide unit with HI/LO registers. It consumes the
//  ID/EX latch outputs (ALUOp, function field, Rs/Rt data). It executes MULT/MULTU/DIV/DIVU
//  over multiple cycles and serves MFHI/MFLO/MTHI/MTLO. While busy it drives outStall,
//  which deasserts the ID/EX latch enable and holds IF/ID/PC.
// PARAMETERS
//  DATA_WIDTH  32  operand/HI/LO width; iteration count = DATA_WIDTH
// PORTS
//  clk           in   1   pipeline clock, rising edge
//  reset         in   1   asynchronous, active-high; forces all state to reset values
//  inValid       in   1   EX holds a real instruction (0 = bubble)
//  inALUOp       in   2   from ID/EX; 2'b10 = R-type, only then is inFunction decoded
//  inFunction    in   6   from ID/EX function field
//  inDataRs      in   32  Rs operand (dividend / multiplicand / MTxx source)
//  inDataRt      in   32  Rt operand (divisor / multiplier)
//  outStall      out  1   1 = hold ID/EX latch and everything upstream
//  outMfValid    out  1   1 = EX instruction is MFHI/MFLO and outMfResult is valid
//  outMfResult   out  32  HI (MFHI) or LO (MFLO); feeds the EX result mux
//  outHi, outLo  out  32  architectural HI/LO registers
//  outDone       out  1   one-cycle pulse in the cycle a mul/div result is committed
// BEHAVIOUR
//  Decode (only when inValid & inALUOp==2'b10):
//   MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
//  Reset values: state=IDLE, HI=LO=0, counter=0, outStall=0, outDone=0, outMfValid=0, outMfResult=0.
//  FSM: IDLE -> MUL | DIV -> FIX -> DONE -> IDLE.
//  IDLE:
//   - start op decoded: latch |Rs| and |Rt| (signed ops) or raw values, plus result sign.
//     outStall=1 combinationally in the same cycle; go to MUL or DIV; counter=0.
//   - DIV/DIVU with Rt==0: no iteration; go straight to FIX with LO=all ones, HI=Rs.
//  MUL: shift-add, 1 bit/cycle, 64-bit accumulator. DIV: restoring, 1 quotient bit/cycle.
//   - Leave after DATA_WIDTH cycles (counter==DATA_WIDTH-1) to FIX.
//  FIX: apply sign. MULT: negate 64-bit product if signs differ. DIV: quotient negated if
//   signs differ; remainder takes dividend sign.
//   - On the FIX->DONE edge, write HI=product[63:32]/remainder and LO=product[31:0]/quotient.
//  DONE: outStall=0, outDone=1; no new start is accepted (EX still holds the mul/div); -> IDLE.
//  outStall=1 in IDLE-with-start, MUL, DIV and FIX; 0 in DONE and otherwise.
//  Latency: start seen in cycle T; DONE in cycle T+DATA_WIDTH+2 (T+2 for divide-by-zero);
//   ID/EX advances on the edge ending DONE.
//  MFHI/MFLO:
//   - In IDLE: outMfResult = HI/LO combinationally, outMfValid=1, no stall.
//   - In any busy state: stalled with the rest of the pipe.
//  MTHI/MTLO in IDLE: write HI/LO = Rs at the clock edge; no stall.
//  Overflow: DIV 32'h80000000 / -1 gives LO=32'h80000000, HI=0 (no trap).
//  Unsigned ops use raw operands and have no FIX sign change.
//  inValid=0 or non-muldiv function in IDLE: no state change, outMfValid=0.
//  Inputs are ignored while busy; operands are held in internal registers.
//  Reset asserted mid-operation aborts immediately: IDLE, HI=LO=0, outStall=0 without waiting for a clock.
// TESTING
//  1. MULTU Rs=32'hFFFFFFFF, Rt=2 -> outStall high 34 cycles; DONE: HI=1, LO=32'hFFFFFFFE, outDone pulse.
//  2. MULT Rs=-3, Rt=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. Then MFLO next instr -> outMfResult=32'hFFFFFFEB, outMfValid=1, no stall.
//  3. DIV Rs=-7, Rt=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
//     DIVU Rs=100, Rt=7 -> LO=14, HI=2.
//  4. DIVU Rs=5, Rt=0 -> DONE at T+2, LO=32'hFFFFFFFF, HI=5.
//     DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
//  5. MTHI Rs=32'h12345678 then MFHI -> 32'h12345678.
//     MFHI held during an active MULT -> stalled until DONE, then returns the new HI.
//  6. Assert reset at cycle 10 of a DIV -> outStall=0, HI=LO=0 asynchronously.
//     Next DIVU 9/3 after release -> LO=3, HI=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies by shift-add and divides by restoring, one bit per cycle, and stalls the pipe while busy.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inValid,
  input  logic [1:0]            inALUOp,
  input  logic [5:0]            inFunction,
  input  logic [DATA_WIDTH-1:0] inDataRs,
  input  logic [DATA_WIDTH-1:0] inDataRt,
  output logic                  outStall,
  output logic                  outMfValid,
  output logic [DATA_WIDTH-1:0] outMfResult,
  output logic [DATA_WIDTH-1:0] outHi,
  output logic [DATA_WIDTH-1:0] outLo,
  output logic                  outDone
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]   cnt_reg;
  logic [2*DW-1:0] acc_reg;
  logic [DW-1:0]   opnd_reg;
  logic            neg_lo_reg;
  logic            neg_hi_reg;
  logic            is_div_reg;
  logic [DW-1:0]   hi_reg;
  logic [DW-1:0]   lo_reg;

  // Instruction decode
  logic rtype;
  logic op_mult, op_multu, op_div, op_divu;
  logic op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic op_start, op_signed, op_is_div, rt_zero;
  logic rs_neg, rt_neg;
  logic [DW-1:0] rs_abs, rt_abs;

  assign rtype     = inValid && (inALUOp == 2'b10);
  assign op_mult   = rtype && (inFunction == F_MULT);
  assign op_multu  = rtype && (inFunction == F_MULTU);
  assign op_div    = rtype && (inFunction == F_DIV);
  assign op_divu   = rtype && (inFunction == F_DIVU);
  assign op_mfhi   = rtype && (inFunction == F_MFHI);
  assign op_mflo   = rtype && (inFunction == F_MFLO);
  assign op_mthi   = rtype && (inFunction == F_MTHI);
  assign op_mtlo   = rtype && (inFunction == F_MTLO);
  assign op_start  = op_mult || op_multu || op_div || op_divu;
  assign op_signed = op_mult || op_div;
  assign op_is_div = op_div || op_divu;
  assign rt_zero   = (inDataRt == '0);
  assign rs_neg    = op_signed && inDataRs[DW-1];
  assign rt_neg    = op_signed && inDataRt[DW-1];
  assign rs_abs    = rs_neg ? -inDataRs : inDataRs;
  assign rt_abs    = rt_neg ? -inDataRt : inDataRt;

  // Multiply step: acc holds {partial product, remaining multiplier bits}
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_acc_next;

  assign mul_sum      = {1'b0, acc_reg[2*DW-1:DW]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_acc_next = {mul_sum, acc_reg[DW-1:1]};

  // Divide step: acc holds {partial remainder, dividend bits / quotient bits}
  logic [DW:0]     div_shift;
  logic [DW+1:0]   div_diff;
  logic            div_ok;
  logic [2*DW-1:0] div_acc_next;

  assign div_shift    = acc_reg[2*DW-1:DW-1];
  assign div_diff     = {1'b0, div_shift} - {2'b00, opnd_reg};
  assign div_ok       = !div_diff[DW+1];
  assign div_acc_next = div_ok ? {div_diff[DW-1:0], acc_reg[DW-2:0], 1'b1}
                               : {div_shift[DW-1:0], acc_reg[DW-2:0], 1'b0};

  // Sign fix-up; the divide-by-zero path clears both negate flags so its raw values pass through
  logic [2*DW-1:0] prod_neg;
  logic [DW-1:0]   fix_hi, fix_lo;

  assign prod_neg = -acc_reg;

  always_comb begin
    fix_hi = acc_reg[2*DW-1:DW];
    fix_lo = acc_reg[DW-1:0];
    if (is_div_reg) begin
      if (neg_hi_reg) fix_hi = -acc_reg[2*DW-1:DW];
      if (neg_lo_reg) fix_lo = -acc_reg[DW-1:0];
    end else if (neg_lo_reg) begin
      fix_hi = prod_neg[2*DW-1:DW];
      fix_lo = prod_neg[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Outputs are gated by reset so an abort takes effect before the next edge
  always_comb begin
    state_next  = state_reg;
    outStall    = 1'b0;
    outDone     = 1'b0;
    outMfValid  = 1'b0;
    outMfResult = '0;
    if (!reset) begin
      case (state_reg)
        S_IDLE: begin
          if (op_start) begin
            outStall = 1'b1;
            if (op_is_div && rt_zero) state_next = S_FIX;
            else if (op_is_div)       state_next = S_DIV;
            else                      state_next = S_MUL;
          end else if (op_mfhi) begin
            outMfValid  = 1'b1;
            outMfResult = hi_reg;
          end else if (op_mflo) begin
            outMfValid  = 1'b1;
            outMfResult = lo_reg;
          end
        end
        S_MUL, S_DIV: begin
          outStall = 1'b1;
          if (cnt_reg == CW'(DW - 1)) state_next = S_FIX;
        end
        S_FIX: begin
          outStall   = 1'b1;
          state_next = S_DONE;
        end
        S_DONE: begin
          outDone    = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      is_div_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (op_start) begin
            cnt_reg    <= '0;
            is_div_reg <= op_is_div;
            if (op_is_div && rt_zero) begin
              acc_reg    <= {inDataRs, {DW{1'b1}}};
              neg_lo_reg <= 1'b0;
              neg_hi_reg <= 1'b0;
            end else if (op_is_div) begin
              acc_reg    <= {{DW{1'b0}}, rs_abs};
              opnd_reg   <= rt_abs;
              neg_lo_reg <= rs_neg ^ rt_neg;
              neg_hi_reg <= rs_neg;
            end else begin
              acc_reg    <= {{DW{1'b0}}, rt_abs};
              opnd_reg   <= rs_abs;
              neg_lo_reg <= rs_neg ^ rt_neg;
              neg_hi_reg <= 1'b0;
            end
          end else if (op_mthi) begin
            hi_reg <= inDataRs;
          end else if (op_mtlo) begin
            lo_reg <= inDataRs;
          end
        end
        S_MUL: begin
          acc_reg <= mul_acc_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_DIV: begin
          acc_reg <= div_acc_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        S_FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign outHi = hi_reg;
  assign outLo = lo_reg;

endmodule
